// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding fetch: valid/stall issue, redirects, fetch count.
// Optional PC limit with HALT state enabled by defining PC_SEQ_LIMIT_EN.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_LIMIT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
    output logic [31:0]         fetch_count,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

`ifdef PC_SEQ_LIMIT_EN
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        RUN
    } state_t;
`endif

    state_t              state_q;
    state_t              state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [31:0]         count_q;
    logic [31:0]         count_d;
    logic                valid_q;
    logic                halted_q;
    logic                limit_hit;
    logic                halt_next;
    logic [31:0]         count_inc;

    // Zero-extend so a narrow pc never aliases a wide limit value.
`ifdef PC_SEQ_LIMIT_EN
    assign limit_hit = (32'(pc_q) == PC_LIMIT);
    assign halt_next = (state_d == HALT);
`else
    logic unused_limit;
    assign unused_limit = (32'(pc_q) == PC_LIMIT);
    assign limit_hit    = 1'b0;
    assign halt_next    = 1'b0;
`endif

    assign count_inc = (count_q == 32'hFFFF_FFFF) ? count_q
                                                  : count_q + 32'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_target;
            state_d = enable ? RUN : IDLE;
        end else if (!enable) begin
            if (state_q == RUN) begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (!stall) begin
                        count_d = count_inc;
                        if (limit_hit) begin
`ifdef PC_SEQ_LIMIT_EN
                            state_d = HALT;
`endif
                        end else begin
                            pc_d = pc_q + PC_ONE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= PC_RST;
            count_q  <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            valid_q  <= (state_d == RUN);
            halted_q <= halt_next;
        end
    end

    assign pc          = pc_q;
    assign pc_valid    = valid_q;
    assign fetch_count = count_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table with scoreboard, plus wrap and
// limit sequences on extra instances.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] fetch_count;
    logic        halted;

    logic        w_reset;
    logic        w_enable;
    logic [3:0]  w_pc;
    logic        w_pc_valid;
    logic [31:0] w_count;
    logic        w_halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pc_sequencer #(
        .PC_WIDTH(32),
        .RESET_PC(0),
        .PC_LIMIT(255)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .fetch_count    (fetch_count),
        .halted         (halted)
    );

    pc_sequencer #(
        .PC_WIDTH(4),
        .RESET_PC(14),
        .PC_LIMIT(5)
    ) u_wrap (
        .clock          (clock),
        .reset          (w_reset),
        .enable         (w_enable),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_target(4'd0),
        .pc             (w_pc),
        .pc_valid       (w_pc_valid),
        .fetch_count    (w_count),
        .halted         (w_halted)
    );

`ifdef PC_SEQ_LIMIT_EN
    logic        l_reset;
    logic        l_enable;
    logic        l_rv;
    logic [31:0] l_tgt;
    logic [31:0] l_pc;
    logic        l_pc_valid;
    logic [31:0] l_count;
    logic        l_halted;

    pc_sequencer #(
        .PC_WIDTH(32),
        .RESET_PC(0),
        .PC_LIMIT(3)
    ) u_lim (
        .clock          (clock),
        .reset          (l_reset),
        .enable         (l_enable),
        .stall          (1'b0),
        .redirect_valid (l_rv),
        .redirect_target(l_tgt),
        .pc             (l_pc),
        .pc_valid       (l_pc_valid),
        .fetch_count    (l_count),
        .halted         (l_halted)
    );
`endif

    typedef struct {
        logic        rst;
        logic        en;
        logic        st;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic [31:0] cnt;
        logic        h;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[22];

    function automatic vec_t mk(logic r, logic e, logic s, logic rv,
                                logic [31:0] t, logic [31:0] p,
                                logic v, logic [31:0] c);
        vec_t x;
        x.rst = r; x.en = e; x.st = s; x.rv = rv; x.tgt = t;
        x.e_pc = p; x.e_v = v; x.e_cnt = c;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(int idx);
        exp_t e;
        exp_t g;
        reset           = vecs[idx].rst;
        enable          = vecs[idx].en;
        stall           = vecs[idx].st;
        redirect_valid  = vecs[idx].rv;
        redirect_target = vecs[idx].tgt;
        e.pc  = vecs[idx].e_pc;
        e.v   = vecs[idx].e_v;
        e.cnt = vecs[idx].e_cnt;
        e.h   = 1'b0;
        sb.push_back(e);
        @(posedge clock);
        #1;
        g = sb.pop_front();
        chk($sformatf("vec%0d pc", idx), pc, g.pc);
        chk($sformatf("vec%0d pc_valid", idx), 32'(pc_valid), 32'(g.v));
        chk($sformatf("vec%0d fetch_count", idx), fetch_count, g.cnt);
        chk($sformatf("vec%0d halted", idx), 32'(halted), 32'(g.h));
    endtask

    task automatic wchk(string name, logic [3:0] p, logic v, logic [31:0] c);
        @(posedge clock);
        #1;
        chk({name, " pc"}, 32'(w_pc), 32'(p));
        chk({name, " pc_valid"}, 32'(w_pc_valid), 32'(v));
        chk({name, " count"}, w_count, c);
        chk({name, " halted"}, 32'(w_halted), 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'd0;
        w_reset = 1'b1; w_enable = 1'b0;
`ifdef PC_SEQ_LIMIT_EN
        l_reset = 1'b1; l_enable = 1'b0; l_rv = 1'b0; l_tgt = 32'd0;
`endif
        //          rst en st rv  tgt     pc     v  cnt
        vecs[0]  = mk(0, 1, 0, 0, 32'h0,  32'h0,  1, 0);
        vecs[1]  = mk(0, 1, 0, 0, 32'h0,  32'h1,  1, 1);
        vecs[2]  = mk(0, 1, 0, 0, 32'h0,  32'h2,  1, 2);
        vecs[3]  = mk(0, 1, 1, 0, 32'h0,  32'h2,  1, 2);
        vecs[4]  = mk(0, 1, 1, 0, 32'h0,  32'h2,  1, 2);
        vecs[5]  = mk(0, 1, 0, 0, 32'h0,  32'h3,  1, 3);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,  32'h4,  1, 4);
        vecs[7]  = mk(0, 1, 0, 0, 32'h0,  32'h5,  1, 5);
        vecs[8]  = mk(0, 1, 1, 1, 32'h40, 32'h40, 1, 5);
        vecs[9]  = mk(0, 1, 0, 0, 32'h0,  32'h41, 1, 6);
        vecs[10] = mk(0, 1, 0, 1, 32'h80, 32'h80, 1, 6);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,  32'h80, 0, 6);
        vecs[12] = mk(0, 0, 0, 1, 32'h20, 32'h20, 0, 6);
        vecs[13] = mk(0, 1, 0, 0, 32'h0,  32'h20, 1, 6);
        vecs[14] = mk(0, 1, 0, 0, 32'h0,  32'h21, 1, 7);
        vecs[15] = mk(0, 0, 0, 1, 32'h30, 32'h30, 0, 7);
        vecs[16] = mk(0, 1, 0, 1, 32'h50, 32'h50, 1, 7);
        vecs[17] = mk(0, 1, 0, 0, 32'h0,  32'h51, 1, 8);
        vecs[18] = mk(0, 1, 0, 0, 32'h0,  32'h52, 1, 9);
        vecs[19] = mk(1, 1, 1, 1, 32'h99, 32'h0,  0, 0);
        vecs[20] = mk(0, 1, 0, 0, 32'h0,  32'h0,  1, 0);
        vecs[21] = mk(0, 1, 0, 0, 32'h0,  32'h1,  1, 1);

        @(posedge clock);
        #1;
        chk("reset pc", pc, 32'h0);
        chk("reset pc_valid", 32'(pc_valid), 32'd0);
        chk("reset fetch_count", fetch_count, 32'd0);
        chk("reset halted", 32'(halted), 32'd0);

        for (int i = 0; i < 22; i++) begin
            apply(i);
        end

        w_reset = 1'b0;
        w_enable = 1'b1;
        wchk("wrap0", 4'd14, 1'b1, 32'd0);
        wchk("wrap1", 4'd15, 1'b1, 32'd1);
        wchk("wrap2", 4'd0,  1'b1, 32'd2);
        wchk("wrap3", 4'd1,  1'b1, 32'd3);

`ifdef PC_SEQ_LIMIT_EN
        l_reset = 1'b0;
        l_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("lim run%0d pc", i), l_pc, 32'(i));
            chk($sformatf("lim run%0d valid", i), 32'(l_pc_valid), 32'd1);
            chk($sformatf("lim run%0d count", i), l_count, 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("lim halt%0d halted", i), 32'(l_halted), 32'd1);
            chk($sformatf("lim halt%0d valid", i), 32'(l_pc_valid), 32'd0);
            chk($sformatf("lim halt%0d pc", i), l_pc, 32'd3);
            chk($sformatf("lim halt%0d count", i), l_count, 32'd4);
        end
        l_rv = 1'b1;
        l_tgt = 32'h10;
        @(posedge clock);
        #1;
        l_rv = 1'b0;
        chk("lim redir pc", l_pc, 32'h10);
        chk("lim redir valid", 32'(l_pc_valid), 32'd1);
        chk("lim redir halted", 32'(l_halted), 32'd0);
        chk("lim redir count", l_count, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that drives the `pc` input of the fetch stage, replacing the free-running PC register currently kept in the bench. It produces one instruction address per cycle under a valid/stall handshake. It also accepts redirects (branch/jump targets) and keeps a count of issued fetches. It sits upstream of `fetch` and is the sending end of the PC→fetch interface.

## Interface
- `PC_WIDTH`, 32: width of `pc` and `redirect_target`. PC is a word index: sequential step is +1.
- `RESET_PC`, 0: PC value loaded by reset.
- `PC_LIMIT`, 255: last address issued before halting. Used only when `PC_SEQ_LIMIT_EN` is defined.

Ports:
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run request; low pauses issue.
- `stall` in 1: fetch cannot accept the current `pc` this cycle.
- `redirect_valid` in 1: load `redirect_target` as next PC.
- `redirect_target` in PC_WIDTH: redirect address.
- `pc` out PC_WIDTH: address presented to fetch.
- `pc_valid` out 1: `pc` is a live fetch request.
- `fetch_count` out 32: number of issued fetches, saturating.
- `halted` out 1: PC limit reached.

## Operation
- **Issue** = any cycle with `pc_valid`=1 and `stall`=0 and `redirect_valid`=0. Fetch consumes `pc` on that rising edge.
- State machine states: IDLE, RUN, HALT. HALT exists only with the macro.
- Update priority: `reset` > `redirect_valid` > `enable`=0 > `stall` > advance.
- IDLE:
  - `pc_valid`=0.
  - `enable`=1 → RUN. `pc` is unchanged, so the first issued address is the current `pc`.
  - `redirect_valid` loads `pc` and the block stays IDLE, unless `enable`=1, in which case it goes to RUN with `pc`=target.
- RUN:
  - `pc_valid`=1.
  - Issue → `pc`<=`pc`+1 and `fetch_count`+1.
  - `stall` → hold `pc` and count.
  - `redirect_valid` → `pc`<=target and count unchanged. The current `pc` is discarded even when not stalled. Stay RUN while `enable`=1.
  - `enable`=0 → IDLE with `pc` held (`pc` loads the target if a redirect arrives in the same cycle).
- HALT:
  - `pc_valid`=0, `halted`=1, `pc` held.
  - `redirect_valid` → `pc`<=target, `halted`<=0, then RUN if `enable`=1, else IDLE.
  - `enable` alone has no effect.
- Arithmetic:
  - `pc` increment is modulo 2^PC_WIDTH: all-ones wraps to 0 with no flag.
  - `fetch_count` saturates at 0xFFFF_FFFF.
- Reset values: `pc`=RESET_PC, `pc_valid`=0, `fetch_count`=0, `halted`=0, state IDLE.
- Reset mid-run:
  - Applies on the next edge regardless of `stall`/`redirect_valid`/`enable`.
  - The in-flight `pc` is dropped.
  - With `enable` held high, RUN resumes on the first edge after `reset` deasserts.

## Timing
- All outputs are registered; no combinational input→output path.
- `stall`/`redirect_valid`/`enable` sampled at edge N take effect on outputs after edge N.
- Redirect-to-valid-target latency: 1 cycle.
- Enable-to-first-`pc_valid` latency: 1 cycle from IDLE.
- Steady state: one issue per cycle, gapless, while `stall`=0.

## Configuration
- `PC_SEQ_LIMIT_EN` defined:
  - An issue in RUN with `pc`==PC_LIMIT counts normally and enters HALT.
  - `pc` stays at PC_LIMIT (no increment) and `halted` rises on the same edge.
- `PC_SEQ_LIMIT_EN` undefined:
  - HALT state absent, `halted` tied 0, PC_LIMIT ignored.
  - `pc` runs indefinitely with wrap-around.

## Test plan
- Reset 1 cycle, then `enable`=1 → `pc_valid` rises next cycle. `pc` 0,1,2,3 on successive cycles; `fetch_count` 0,1,2,3 alongside.
- Running, `stall`=1 for 2 cycles while `pc`=2 → `pc` reads 2 for 3 cycles and `fetch_count` holds at 2; then 3.
- `redirect_valid`=1, target 0x40, together with `stall`=1 at `pc`=5 → next `pc`=0x40, `pc_valid`=1, `fetch_count` unchanged; then 0x41.
- PC_WIDTH=4, RESET_PC=14, `enable`=1 → `pc` 14,15,0,1 and `fetch_count` reaches 3.
- With `PC_SEQ_LIMIT_EN`, PC_LIMIT=3 → issues 0..3. Then `halted`=1, `pc_valid`=0, `pc`=3, `fetch_count`=4, holding while `enable`=1. Redirect to 0x10 → RUN at 0x10, `halted`=0.
- `reset` asserted at `pc`=5 with `enable` high → next cycle `pc`=RESET_PC, `pc_valid`=0, `fetch_count`=0. First edge after release → `pc_valid`=1 at RESET_PC.
